uart_rx_ovs: RTL and testbench

Parametrised oversampling UART receiver, the next-generation receive path for the UART IP. It takes the raw `rx` pin and an oversample tick from the baud generator. It decodes configurable frames of 5..`MAX_BITS` data bits with none/even/odd/mark/space parity and 1 or 2 stop bits, using 3-sample majority voting and false-start rejection. It presents each frame through a single-entry valid/ready holding register with separate frame, parity, break and overrun status.

---
 rtl/uart_rx_ovs_pkg.sv | 27 ++
 rtl/uart_rx_ovs_if.sv | 22 ++
 rtl/uart_rx_ovs_sync.sv | 26 ++
 rtl/uart_rx_ovs.sv | 208 ++++++++++++++++++++
 tb/tb_uart_rx_ovs.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_ovs_pkg.sv
// Shared UART receive-path types and constants.
package uart_pkg;

   localparam int unsigned sync_stages = 2;

   typedef enum logic [2:0] {
      PAR_NONE  = 3'd0,
      PAR_EVEN  = 3'd1,
      PAR_ODD   = 3'd2,
      PAR_MARK  = 3'd3,
      PAR_SPACE = 3'd4
   } uart_parity_e;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP1  = 3'd4,
      ST_STOP2  = 3'd5
   } uart_rx_state_e;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_rx_ovs_if.sv
// Receive-word handshake: holding-register data plus status, valid/ready flow control.
interface uart_rx_ovs_if #(
   parameter int unsigned MAX_BITS = 9
) ();
   logic [MAX_BITS-1:0] rx_data;
   logic                rx_valid;
   logic                rx_ready;
   logic                frame_err;
   logic                parity_err;
   logic                break_det;
   logic                overrun;

   modport master (
      output rx_data, rx_valid, frame_err, parity_err, break_det, overrun,
      input  rx_ready
   );

   modport slave (
      input  rx_data, rx_valid, frame_err, parity_err, break_det, overrun,
      output rx_ready
   );
endinterface

// File: rtl/uart_rx_ovs_sync.sv
// Serial input synchroniser (reset to idle-high) with a one-cycle falling-edge pulse.
module uart_rx_sync
   import uart_pkg::*;
(
   input  logic clk,
   input  logic arst_n,
   input  logic rx,
   output logic rx_s,
   output logic rx_fall
);
   logic [sync_stages-1:0] sync_q;
   logic                   prev_q;

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         sync_q <= '1;
         prev_q <= 1'b1;
      end else begin
         sync_q <= {sync_q[sync_stages-2:0], rx};
         prev_q <= sync_q[sync_stages-1];
      end
   end

   assign rx_s    = sync_q[sync_stages-1];
   assign rx_fall = prev_q & ~rx_s;
endmodule

// File: rtl/uart_rx_ovs.sv
// Oversampling UART receiver: 3-sample majority bit decisions, false-start rejection
// and a single-entry holding register with frame/parity/break/overrun status.
module uart_rx_ovs
   import uart_pkg::*;
#(
   parameter int unsigned OVS      = 16,
   parameter int unsigned MAX_BITS = 9
) (
   input  logic          clk,
   input  logic          arst_n,
   input  logic          active,
   input  logic          rx,
   input  logic          recv_clk_en,
   input  logic [3:0]    data_bits,
   input  logic [2:0]    parity_type,
   input  logic          stop_type,
   output logic          busy,
   uart_rx_ovs_if.master rxo
);
   localparam int unsigned   PW      = $clog2(OVS);
   localparam logic [PW-1:0] PH_LAST = PW'(OVS - 1);
   localparam logic [PW-1:0] PH_S0   = PW'(OVS / 2 - 1);
   localparam logic [PW-1:0] PH_S1   = PW'(OVS / 2);
   localparam logic [PW-1:0] PH_DEC  = PW'(OVS / 2 + 1);
   localparam logic [3:0]    NB_MIN  = 4'd5;
   localparam logic [3:0]    NB_MAX  = 4'(MAX_BITS);

   logic rx_s, rx_fall;

   uart_rx_sync u_sync (
      .clk    (clk),
      .arst_n (arst_n),
      .rx     (rx),
      .rx_s   (rx_s),
      .rx_fall(rx_fall)
   );

   uart_rx_state_e      state_q, state_d;
   logic [PW-1:0]       ph_q, ph_d;
   logic [3:0]          cnt_q, cnt_d, nbits_q, nbits_d;
   uart_parity_e        par_q, par_d;
   logic                stop2_q, stop2_d;
   logic [1:0]          samp_q, samp_d;
   logic [MAX_BITS-1:0] shift_q, shift_d, data_q;
   logic                perr_q, perr_d, ferr_q, ferr_d, ones_q, ones_d;
   logic                valid_q, fe_q, pe_q, bd_q, ov_q;
   logic                dec, wrap, bit_v, exp_par, done;

   assign dec   = recv_clk_en && (ph_q == PH_DEC);
   assign wrap  = recv_clk_en && (ph_q == PH_LAST);
   assign bit_v = maj3(samp_q[1], samp_q[0], rx_s);

   always_comb begin
      case (par_q)
         PAR_EVEN: exp_par = ^shift_q;
         PAR_ODD:  exp_par = ~^shift_q;
         PAR_MARK: exp_par = 1'b1;
         default:  exp_par = 1'b0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      ph_d    = ph_q;
      cnt_d   = cnt_q;
      nbits_d = nbits_q;
      par_d   = par_q;
      stop2_d = stop2_q;
      samp_d  = samp_q;
      shift_d = shift_q;
      perr_d  = perr_q;
      ferr_d  = ferr_q;
      ones_d  = ones_q;
      done    = 1'b0;

      if (!active) begin
         state_d = ST_IDLE;
         ph_d    = '0;
      end else if (state_q == ST_IDLE) begin
         if (rx_fall) begin
            state_d = ST_START;
            ph_d    = '0;
            cnt_d   = '0;
            shift_d = '0;
            perr_d  = 1'b0;
            ferr_d  = 1'b0;
            ones_d  = 1'b0;
            nbits_d = (data_bits < NB_MIN) ? NB_MIN :
                      (data_bits > NB_MAX) ? NB_MAX : data_bits;
            par_d   = (parity_type inside {[3'd1:3'd4]}) ? uart_parity_e'(parity_type) : PAR_NONE;
            stop2_d = stop_type;
         end
      end else if (recv_clk_en) begin
         ph_d = (ph_q == PH_LAST) ? '0 : ph_q + 1'b1;
         if (ph_q == PH_S0) samp_d[1] = rx_s;
         if (ph_q == PH_S1) samp_d[0] = rx_s;

         case (state_q)
            ST_START: begin
               if (dec && bit_v) begin
                  state_d = ST_IDLE;
                  ph_d    = '0;
               end else if (wrap) begin
                  state_d = ST_DATA;
               end
            end
            ST_DATA: begin
               if (dec) begin
                  for (int unsigned i = 0; i < MAX_BITS; i++)
                     if (4'(i) == cnt_q) shift_d[i] = bit_v;
                  cnt_d  = cnt_q + 4'd1;
                  ones_d = ones_q | bit_v;
               end
               if (wrap && cnt_q == nbits_q)
                  state_d = (par_q == PAR_NONE) ? ST_STOP1 : ST_PARITY;
            end
            ST_PARITY: begin
               if (dec) begin
                  perr_d = bit_v ^ exp_par;
                  ones_d = ones_q | bit_v;
               end
               if (wrap) state_d = ST_STOP1;
            end
            // A single stop bit completes at its decision point so a start bit
            // immediately following it can still be caught.
            ST_STOP1: begin
               if (dec) begin
                  ferr_d = ferr_q | ~bit_v;
                  ones_d = ones_q | bit_v;
                  if (!stop2_q) begin
                     done    = 1'b1;
                     state_d = ST_IDLE;
                     ph_d    = '0;
                  end
               end else if (wrap && stop2_q) begin
                  state_d = ST_STOP2;
               end
            end
            ST_STOP2: begin
               if (dec) begin
                  ferr_d  = ferr_q | ~bit_v;
                  ones_d  = ones_q | bit_v;
                  done    = 1'b1;
                  state_d = ST_IDLE;
                  ph_d    = '0;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q <= ST_IDLE;
         ph_q    <= '0;
         cnt_q   <= '0;
         nbits_q <= NB_MIN;
         par_q   <= PAR_NONE;
         stop2_q <= 1'b0;
         samp_q  <= '1;
         shift_q <= '0;
         perr_q  <= 1'b0;
         ferr_q  <= 1'b0;
         ones_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ph_q    <= ph_d;
         cnt_q   <= cnt_d;
         nbits_q <= nbits_d;
         par_q   <= par_d;
         stop2_q <= stop2_d;
         samp_q  <= samp_d;
         shift_q <= shift_d;
         perr_q  <= perr_d;
         ferr_q  <= ferr_d;
         ones_q  <= ones_d;
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         data_q  <= '0;
         valid_q <= 1'b0;
         fe_q    <= 1'b0;
         pe_q    <= 1'b0;
         bd_q    <= 1'b0;
         ov_q    <= 1'b0;
      end else if (done) begin
         data_q  <= shift_q;
         valid_q <= 1'b1;
         fe_q    <= ferr_d;
         pe_q    <= perr_q;
         bd_q    <= ~ones_d;
         ov_q    <= valid_q & ~rxo.rx_ready;
      end else if (valid_q && rxo.rx_ready) begin
         valid_q <= 1'b0;
      end
   end

   assign busy           = (state_q != ST_IDLE);
   assign rxo.rx_data    = data_q;
   assign rxo.rx_valid   = valid_q;
   assign rxo.frame_err  = fe_q;
   assign rxo.parity_err = pe_q;
   assign rxo.break_det  = bd_q;
   assign rxo.overrun    = ov_q;
endmodule

// File: tb/tb_uart_rx_ovs.sv
// Scoreboard bench for uart_rx_ovs: frames are built from a bit-list reference model,
// expected words are queued at send time and checked by an independent consumer monitor.
module tb_uart_rx_ovs;
   import uart_pkg::*;

   localparam int unsigned OVS      = 16;
   localparam int unsigned MAX_BITS = 9;
   localparam int unsigned TICK_DIV = 3;

   typedef struct {
      logic [8:0] data;
      logic       fe;
      logic       pe;
      logic       bd;
      logic       ov;
   } exp_t;

   logic       clk = 1'b0;
   logic       arst_n = 1'b1;
   logic       active = 1'b0;
   logic       rx = 1'b1;
   logic       recv_clk_en = 1'b0;
   logic [3:0] data_bits = 4'd8;
   logic [2:0] parity_type = 3'd0;
   logic       stop_type = 1'b0;
   logic       busy;

   int   errors = 0;
   int   checks = 0;
   bit   coincide_mode = 1'b0;
   exp_t sbq[$];

   uart_rx_ovs_if #(.MAX_BITS(MAX_BITS)) rxo ();

   uart_rx_ovs #(.OVS(OVS), .MAX_BITS(MAX_BITS)) dut (
      .clk        (clk),
      .arst_n     (arst_n),
      .active     (active),
      .rx         (rx),
      .recv_clk_en(recv_clk_en),
      .data_bits  (data_bits),
      .parity_type(parity_type),
      .stop_type  (stop_type),
      .busy       (busy),
      .rxo        (rxo)
   );

   always #5 clk = ~clk;

   initial begin
      int c;
      c = 0;
      forever begin
         @(posedge clk);
         #1;
         c = (c + 1) % TICK_DIV;
         recv_clk_en = (c == 0);
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic wait_ticks(input int n);
      int k;
      k = 0;
      while (k < n) begin
         @(posedge clk);
         if (recv_clk_en) k++;
      end
      #1;
   endtask

   task automatic idle_bits(input int n);
      rx = 1'b1;
      wait_ticks(n * OVS);
   endtask

   // Reference model: builds the line bit sequence and derives the expected word.
   task automatic send_frame(input logic [8:0] val, input logic [3:0] nb_cfg,
                             input logic [2:0] pt, input logic st, input bit par_flip,
                             input logic s1, input logic s2, input bit push, input bit ov);
      int   n, ones;
      bit   has_par;
      logic want, pbit;
      logic bits[$];
      exp_t e;
      n = (nb_cfg < 5) ? 5 : (nb_cfg > MAX_BITS) ? MAX_BITS : int'(nb_cfg);
      has_par = (pt >= 3'd1 && pt <= 3'd4);
      e.data = val & 9'((1 << n) - 1);
      ones = $countones(e.data);
      case (pt)
         3'd1:    want = (ones % 2 == 1);
         3'd2:    want = (ones % 2 == 0);
         3'd3:    want = 1'b1;
         default: want = 1'b0;
      endcase
      pbit = want ^ par_flip;
      bits.push_back(1'b0);
      for (int i = 0; i < n; i++) bits.push_back(val[i]);
      if (has_par) bits.push_back(pbit);
      bits.push_back(s1);
      if (st) bits.push_back(s2);
      e.pe = has_par && par_flip;
      e.fe = !s1 || (st && !s2);
      e.bd = (e.data == 9'd0) && !(has_par && pbit) && !s1 && !(st && s2);
      e.ov = ov;
      if (push) sbq.push_back(e);
      data_bits = nb_cfg;
      parity_type = pt;
      stop_type = st;
      foreach (bits[i]) begin
         rx = bits[i];
         wait_ticks(OVS);
         if (i == 0) begin
            data_bits = 4'($urandom);
            parity_type = 3'($urandom);
            stop_type = 1'($urandom);
         end
      end
   endtask

   // Raises rx_ready for the tick cycle carrying the stop decision of an 8N1 frame.
   task automatic pulse_ready();
      int guard, k;
      guard = 0;
      k = 0;
      while (!busy && guard < 2000) begin
         @(posedge clk);
         #2;
         guard++;
      end
      checks++;
      if (!busy) begin
         errors++;
         $display("FAIL pulse_start: got busy=0, expected busy=1 within 2000 cycles");
      end else begin
         while (k < int'(OVS * 9 + OVS / 2 + 1)) begin
            @(posedge clk);
            if (recv_clk_en) k++;
         end
         #2;
         while (!recv_clk_en) begin
            @(posedge clk);
            #2;
         end
         rxo.rx_ready = 1'b1;
         @(posedge clk);
         #2;
         rxo.rx_ready = 1'b0;
      end
   endtask

   initial begin
      exp_t e;
      bit   chk_drop;
      chk_drop = 1'b0;
      forever begin
         @(negedge clk);
         if (chk_drop && !coincide_mode) check("valid_clears", 32'(rxo.rx_valid), 32'd0);
         chk_drop = 1'b0;
         if (arst_n && rxo.rx_valid && rxo.rx_ready) begin
            if (sbq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_word: got data 0x%0h, expected no word", rxo.rx_data);
            end else begin
               e = sbq.pop_front();
               check("rx_data", 32'(rxo.rx_data), 32'(e.data));
               check("flags{fe,pe,bd,ov}",
                     32'({rxo.frame_err, rxo.parity_err, rxo.break_det, rxo.overrun}),
                     32'({e.fe, e.pe, e.bd, e.ov}));
            end
            chk_drop = 1'b1;
         end
      end
   end

   initial begin
      int guard;
      rxo.rx_ready = 1'b0;
      #1 arst_n = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("reset_valid", 32'(rxo.rx_valid), 32'd0);
      check("reset_data", 32'(rxo.rx_data), 32'd0);
      check("reset_flags", 32'({rxo.frame_err, rxo.parity_err, rxo.break_det, rxo.overrun}), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      arst_n = 1'b1;
      active = 1'b1;
      idle_bits(2);

      rxo.rx_ready = 1'b1;
      send_frame(9'h0A5, 4'd8, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      idle_bits(2);
      send_frame(9'h041, 4'd7, 3'd1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      idle_bits(2);
      send_frame(9'h1FF, 4'd9, 3'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      idle_bits(2);
      send_frame(9'h1FF, 4'd9, 3'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      idle_bits(2);

      rxo.rx_ready = 1'b0;
      rx = 1'b0;
      wait_ticks(4);
      check("glitch_busy", 32'(busy), 32'd1);
      rx = 1'b1;
      wait_ticks(OVS);
      check("glitch_idle", 32'(busy), 32'd0);
      check("glitch_no_word", 32'(rxo.rx_valid), 32'd0);
      rxo.rx_ready = 1'b1;
      idle_bits(1);

      data_bits = 4'd8;
      parity_type = 3'd0;
      stop_type = 1'b0;
      sbq.push_back('{data: 9'd0, fe: 1'b1, pe: 1'b0, bd: 1'b1, ov: 1'b0});
      rx = 1'b0;
      wait_ticks(20 * OVS);
      idle_bits(2);

      rxo.rx_ready = 1'b0;
      send_frame(9'h011, 4'd8, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      send_frame(9'h022, 4'd8, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
      idle_bits(1);
      check("overrun_held", 32'(rxo.rx_valid), 32'd1);
      rxo.rx_ready = 1'b1;
      idle_bits(1);

      rxo.rx_ready = 1'b0;
      coincide_mode = 1'b1;
      send_frame(9'h011, 4'd8, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      fork
         send_frame(9'h022, 4'd8, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
         pulse_ready();
      join
      idle_bits(1);
      rxo.rx_ready = 1'b1;
      idle_bits(1);
      coincide_mode = 1'b0;

      rxo.rx_ready = 1'b0;
      send_frame(9'h05A, 4'd8, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      idle_bits(1);
      rx = 1'b0;
      wait_ticks(OVS);
      rx = 1'b1;
      wait_ticks(OVS);
      rx = 1'b0;
      wait_ticks(OVS / 2);
      active = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("abort_idle", 32'(busy), 32'd0);
      check("abort_held_valid", 32'(rxo.rx_valid), 32'd1);
      rx = 1'b1;
      wait_ticks(2 * OVS);
      active = 1'b1;
      idle_bits(1);
      rxo.rx_ready = 1'b1;
      idle_bits(1);

      for (int it = 0; it < 30; it++) begin
         logic [8:0] v;
         logic [3:0] nb;
         logic [2:0] pt;
         logic       st, s1, s2;
         bit         flip;
         int         gap;
         v = 9'($urandom);
         nb = 4'($urandom_range(0, 15));
         pt = 3'($urandom_range(0, 7));
         st = 1'($urandom_range(0, 1));
         flip = ($urandom_range(0, 3) == 0);
         s1 = ($urandom_range(0, 7) != 0);
         s2 = ($urandom_range(0, 7) != 0);
         send_frame(v, nb, pt, st, flip, s1, s2, 1'b1, 1'b0);
         gap = ((st ? s2 : s1) == 1'b0) ? int'($urandom_range(1, 2)) : int'($urandom_range(0, 2));
         idle_bits(gap);
      end
      idle_bits(2);

      guard = 0;
      while (sbq.size() != 0 && guard < 1000) begin
         @(posedge clk);
         guard++;
      end
      check("scoreboard_drained", 32'(sbq.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
